// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the full_adder ripple-carry adder.
package full_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Widest carry chain any legal instance can need: c[0]..c[MAX_WIDTH]
  typedef logic [MAX_WIDTH:0] carry_vec_t;

  // Signed overflow from the carries into and out of the MSB
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell; the leaf of the ripple-carry chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a one-cycle registered result.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("full_adder: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  // Carry ripples LSB to MSB through one cell per bit
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_c;
  assign ovf_c = signed_ovf(c[WIDTH-1], c[WIDTH]);
`endif

  // Result register: loads only on valid input so X on idle inputs never lands here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c[WIDTH];
`ifdef FULL_ADDER_OVF_EN
        Ovf  <= ovf_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1, 8 and 16 against an arithmetic model.
module tb_full_adder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic        v1, a1, b1, c1;
  logic        v8, c8;
  logic [7:0]  a8, b8;
  logic        v16, c16;
  logic [15:0] a16, b16;

  logic        o_v1, o_c1;
  logic [0:0]  o_s1;
  logic        o_v8, o_c8;
  logic [7:0]  o_s8;
  logic        o_v16, o_c16;
  logic [15:0] o_s16;
`ifdef FULL_ADDER_OVF_EN
  logic        o_o1, o_o8, o_o16;
`endif

  // Expected registered state per instance: 0 -> W1, 1 -> W8, 2 -> W16
  logic [63:0] e_sum   [3];
  logic        e_cout  [3];
  logic        e_ovf   [3];
  logic        e_valid [3];

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .out_valid(o_v1), .Sum(o_s1), .Cout(o_c1)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(o_o1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .out_valid(o_v8), .Sum(o_s8), .Cout(o_c8)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(o_o8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .A(a16), .B(b16), .Cin(c16),
    .out_valid(o_v16), .Sum(o_s16), .Cout(o_c16)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(o_o16)
`endif
  );

  always #5 clk = ~clk;

  // Reference: integer addition, overflow from operand/result signs
  function automatic logic [65:0] ref_add(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic ci);
    logic [63:0] mask;
    logic [64:0] full;
    logic        sa, sb, ss, ovf;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + 65'(ci);
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = full[w-1];
    ovf  = (sa == sb) && (ss != sa);
    return {ovf, full[w], full[63:0] & mask};
  endfunction

  task automatic model_step(input int idx, input int unsigned w, input logic v,
                            input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [65:0] r;
    e_valid[idx] = v;
    if (v) begin
      r           = ref_add(w, a, b, ci);
      e_sum[idx]  = r[63:0];
      e_cout[idx] = r[64];
      e_ovf[idx]  = r[65];
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      e_sum[k] = '0; e_cout[k] = 1'b0; e_ovf[k] = 1'b0; e_valid[k] = 1'b0;
    end
  endtask

  // Advance one clock, update the model with what was presented, then settle past the edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      model_step(0, 1, v1, 64'(a1), 64'(b1), c1);
      model_step(1, 8, v8, 64'(a8), 64'(b8), c8);
      model_step(2, 16, v16, 64'(a16), 64'(b16), c16);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;
    model_clear();
    #2;
    checks++;
    if ({o_v1, o_c1, o_s1, o_v8, o_c8, o_s8, o_v16, o_c16, o_s16} !== '0) begin
      failures++;
      $display("FAIL reset_init: got w1=%b%b%h w8=%b%b%h w16=%b%b%h want all zero",
               o_v1, o_c1, o_s1, o_v8, o_c8, o_s8, o_v16, o_c16, o_s16);
    end
    // Valid input at an edge while rst is high must not be captured
    v8 = 1; a8 = 8'hFF; b8 = 8'h01; c8 = 1;
    tick();
    checks++;
    if ({o_v8, o_c8, o_s8} !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold_capture: got v=%b c=%b s=%h want 0 0 00", o_v8, o_c8, o_s8);
    end
    v8 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] tt [8];
    int         idx;
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v1 = 1; a1 = i[0]; b1 = i[1]; c1 = i[2];
      idx = {29'd0, a1, b1, c1};
      tick();
      checks++;
      if ({o_v1, o_s1, o_c1} !== {1'b1, tt[idx]}) begin
        failures++;
        $display("FAIL truth_table abc=%0d%0d%0d: got v=%b s=%b c=%b want v=1 s,c=%b",
                 a1, b1, c1, o_v1, o_s1, o_c1, tt[idx]);
      end
    end
    v1 = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [6], tb [6], ts [6];
    logic       tc [6], tco [6], tov [6];
    ta  = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h7F, 8'h80};
    tb  = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h80};
    tc  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    ts  = '{8'h00, 8'h10, 8'hFF, 8'h00, 8'h80, 8'h00};
    tco = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    tov = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    for (int i = 0; i < 6; i++) begin
      v8 = 1; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      tick();
      checks++;
      if ({o_v8, o_c8, o_s8} !== {1'b1, tco[i], ts[i]}) begin
        failures++;
        $display("FAIL add8_vec%0d: got v=%b c=%b s=%h want v=1 c=%b s=%h",
                 i, o_v8, o_c8, o_s8, tco[i], ts[i]);
      end
`ifdef FULL_ADDER_OVF_EN
      checks++;
      if (o_o8 !== tov[i]) begin
        failures++;
        $display("FAIL ovf8_vec%0d: got %b want %b", i, o_o8, tov[i]);
      end
`else
      if (tov[i] === 1'bx) $display("note: unexpected table entry");
`endif
    end
    v8 = 0;
  endtask

  task automatic test_hold();
    logic [7:0] held_s;
    logic       held_c;
    held_s = e_sum[1][7:0];
    held_c = e_cout[1];
    for (int i = 0; i < 3; i++) begin
      v8 = 0; c8 = $urandom_range(0, 1);
      a8 = (i == 1) ? 8'bx : 8'($urandom);
      b8 = (i == 2) ? 8'bz : 8'($urandom);
      tick();
      checks++;
      if ({o_v8, o_c8, o_s8} !== {1'b0, held_c, held_s}) begin
        failures++;
        $display("FAIL hold_cycle%0d: got v=%b c=%b s=%h want v=0 c=%b s=%h",
                 i, o_v8, o_c8, o_s8, held_c, held_s);
      end
    end
    a8 = 0; b8 = 0;
  endtask

  task automatic test_reset_mid();
    v8 = 1; a8 = 8'h12; b8 = 8'h34; c8 = 1;
    tick();
    v8 = 0;
    checks++;
    if ({o_v8, o_c8, o_s8} !== {1'b1, 1'b0, 8'h47}) begin
      failures++;
      $display("FAIL pre_reset: got v=%b c=%b s=%h want 1 0 47", o_v8, o_c8, o_s8);
    end
    #2 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({o_v1, o_c1, o_s1, o_v8, o_c8, o_s8, o_v16, o_c16, o_s16} !== '0) begin
      failures++;
      $display("FAIL reset_async: got w1=%b%b%h w8=%b%b%h w16=%b%b%h want all zero",
               o_v1, o_c1, o_s1, o_v8, o_c8, o_s8, o_v16, o_c16, o_s16);
    end
`ifdef FULL_ADDER_OVF_EN
    checks++;
    if ({o_o1, o_o8, o_o16} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ovf: got %b%b%b want 000", o_o1, o_o8, o_o16);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      v16 = 1'($urandom_range(0, 1)); a16 = 16'($urandom); b16 = 16'($urandom);
      c16 = 1'($urandom_range(0, 1));
      v8  = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
      c8  = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({o_v16, o_c16, o_s16} !== {e_valid[2], e_cout[2], e_sum[2][15:0]}) begin
        failures++;
        $display("FAIL rand16_%0d: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                 i, o_v16, o_c16, o_s16, e_valid[2], e_cout[2], e_sum[2][15:0]);
      end
      checks++;
      if ({o_v8, o_c8, o_s8} !== {e_valid[1], e_cout[1], e_sum[1][7:0]}) begin
        failures++;
        $display("FAIL rand8_%0d: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                 i, o_v8, o_c8, o_s8, e_valid[1], e_cout[1], e_sum[1][7:0]);
      end
`ifdef FULL_ADDER_OVF_EN
      checks++;
      if ({o_o16, o_o8} !== {e_ovf[2], e_ovf[1]}) begin
        failures++;
        $display("FAIL rand_ovf_%0d: got %b%b want %b%b", i, o_o16, o_o8, e_ovf[2], e_ovf[1]);
      end
`endif
    end
    v16 = 0; v8 = 0;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    test_reset();
    test_truth_table();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
